// File: rtl/axi4_mem_port_arbiter.sv
// Round-robin, burst-locked arbiter that shares one single-port memory between
// the AXI write-data engine (port 0) and the read-data engine (port 1).
module axi4_mem_port_arbiter #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int MEMORY_DEPTH = 1024,
    localparam int ADDR_WIDTH   = $clog2(MEMORY_DEPTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p0_last,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic                  p1_last,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q;
    logic   rr_ptr_q;
    logic   rd_pend_q;
    logic   rd_tag_q;
    logic   acc0;
    logic   acc1;

    assign p0_gnt = (state_q == OWN0);
    assign p1_gnt = (state_q == OWN1);
    assign acc0   = p0_req & p0_gnt;
    assign acc1   = p1_req & p1_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (acc0) begin
            mem_en    = 1'b1;
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (acc1) begin
            mem_en    = 1'b1;
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    // Read data is routed by the tag captured at accept, not by current ownership.
    assign p0_rvalid = rd_pend_q & ~rd_tag_q;
    assign p1_rvalid = rd_pend_q &  rd_tag_q;
    assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= 1'b0;
        end else begin
            rd_pend_q <= mem_en & ~mem_we;
            rd_tag_q  <= acc1;
            unique case (state_q)
                IDLE: begin
                    if (p0_req && p1_req) begin
                        state_q <= rr_ptr_q ? OWN1 : OWN0;
                    end else if (p0_req) begin
                        state_q <= OWN0;
                    end else if (p1_req) begin
                        state_q <= OWN1;
                    end
                end
                OWN0: begin
                    // Lock holds until the owner's last beat or the owner withdraws.
                    if (!p0_req || p0_last) begin
                        rr_ptr_q <= 1'b1;
                        state_q  <= p1_req ? OWN1 : IDLE;
                    end
                end
                OWN1: begin
                    if (!p1_req || p1_last) begin
                        rr_ptr_q <= 1'b0;
                        state_q  <= p0_req ? OWN0 : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_mem_port_arbiter.sv
// Directed bench for axi4_mem_port_arbiter with a behavioural single-port memory.
module tb_axi4_mem_port_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p0_last = 1'b0;
    logic [9:0]  p0_addr = '0;
    logic [31:0] p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0, p1_last = 1'b0;
    logic [9:0]  p1_addr = '0;
    logic [31:0] p1_wdata = '0;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] tb_mem [0:1023];

    int tests = 0;
    int fails = 0;

    axi4_mem_port_arbiter #(.DATA_WIDTH(32), .MEMORY_DEPTH(1024)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_last(p0_last), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_last(p1_last), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic step();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        step();
        step();
        ARESETn = 1'b1;
    endtask

    task automatic test_reset();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h000; p0_last = 1'b1;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h001; p1_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            tests++;
            if ({p0_gnt, p1_gnt, mem_en, p0_rvalid, p1_rvalid} !== 5'b0) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: gnt0=%b gnt1=%b en=%b rv0=%b rv1=%b, required all 0",
                         i, p0_gnt, p1_gnt, mem_en, p0_rvalid, p1_rvalid);
            end
        end
        ARESETn = 1'b1;
        #1;
        tests++;
        if (p0_gnt !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_cyc1: p0_gnt=%b, required 0", p0_gnt);
        end
        step();
        #1;
        tests++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL reset_release_cyc2: gnt0=%b gnt1=%b, required 1 0", p0_gnt, p1_gnt);
        end
        $display("[TB] reset: hold 3 cycles, p0 granted on 2nd cycle after release");
        do_reset();
    endtask

    task automatic test_write_burst();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'h010; p0_wdata = 32'hA0; p0_last = 1'b0;
        #1;
        tests++;
        if ({p0_gnt, p1_gnt, mem_en} !== 3'b000) begin
            fails++;
            $display("FAIL wr_bubble: gnt0=%b gnt1=%b en=%b, required 000", p0_gnt, p1_gnt, mem_en);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            p0_addr = 10'h010 + 10'(i);
            p0_wdata = 32'hA0 + 32'(i);
            p0_last = (i == 3);
            #1;
            tests++;
            if ({p0_gnt, p1_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 10'h010 + 10'(i)
                || mem_wdata !== 32'hA0 + 32'(i)) begin
                fails++;
                $display("FAIL wr_beat%0d: gnt0=%b gnt1=%b en=%b we=%b addr=%h wdata=%h, required 1 0 1 1 %h %h",
                         i, p0_gnt, p1_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                         10'h010 + 10'(i), 32'hA0 + 32'(i));
            end
            $display("[TB] write beat %0d addr=%h data=%h", i, mem_addr, mem_wdata);
            step();
        end
        p0_req = 1'b0;
        #1;
        tests++;
        if ({p0_gnt, p1_gnt, mem_en} !== 3'b000) begin
            fails++;
            $display("FAIL wr_release: gnt0=%b gnt1=%b en=%b, required 000", p0_gnt, p1_gnt, mem_en);
        end
    endtask

    task automatic test_read_latency();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h010; p1_last = 1'b1;
        step();
        #1;
        tests++;
        if ({p0_gnt, p1_gnt, mem_en, mem_we} !== 4'b0110 || mem_addr !== 10'h010) begin
            fails++;
            $display("FAIL rd_accept: gnt0=%b gnt1=%b en=%b we=%b addr=%h, required 0 1 1 0 010",
                     p0_gnt, p1_gnt, mem_en, mem_we, mem_addr);
        end
        step();
        p1_req = 1'b0;
        #1;
        tests++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hA0 || p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin
            fails++;
            $display("FAIL rd_return: rv1=%b rd1=%h rv0=%b rd0=%h, required 1 000000a0 0 00000000",
                     p1_rvalid, p1_rdata, p0_rvalid, p0_rdata);
        end
        $display("[TB] read p1 addr=010 data=%h", p1_rdata);
        step();
        #1;
        tests++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            fails++;
            $display("FAIL rd_one_shot: rv0=%b rv1=%b, required 0 0", p0_rvalid, p1_rvalid);
        end
    endtask

    task automatic test_contention_lock();
        do_reset();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'h020; p0_wdata = 32'hB0; p0_last = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h013; p1_last = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            p0_addr = 10'h020 + 10'(i);
            p0_wdata = 32'hB0 + 32'(i);
            p0_last = (i == 3);
            #1;
            tests++;
            if ({p0_gnt, p1_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 10'h020 + 10'(i)) begin
                fails++;
                $display("FAIL lock_beat%0d: gnt0=%b gnt1=%b en=%b we=%b addr=%h, required 1 0 1 1 %h",
                         i, p0_gnt, p1_gnt, mem_en, mem_we, mem_addr, 10'h020 + 10'(i));
            end
            $display("[TB] contention p0 beat %0d, p1 waiting gnt1=%b", i, p1_gnt);
            step();
        end
        p0_req = 1'b0;
        #1;
        tests++;
        if ({p0_gnt, p1_gnt, mem_en, mem_we} !== 4'b0110 || mem_addr !== 10'h013) begin
            fails++;
            $display("FAIL handover_no_bubble: gnt0=%b gnt1=%b en=%b we=%b addr=%h, required 0 1 1 0 013",
                     p0_gnt, p1_gnt, mem_en, mem_we, mem_addr);
        end
        step();
        p1_req = 1'b0;
        #1;
        tests++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hA3 || {p0_gnt, p1_gnt} !== 2'b00) begin
            fails++;
            $display("FAIL handover_read: rv1=%b rd1=%h gnt0=%b gnt1=%b, required 1 000000a3 0 0",
                     p1_rvalid, p1_rdata, p0_gnt, p1_gnt);
        end
        step();
    endtask

    task automatic test_round_robin();
        // p1 released last, so a tie now favours p0.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h020; p0_last = 1'b1;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h021; p1_last = 1'b1;
        step();
        #1;
        tests++;
        if ({p0_gnt, p1_gnt} !== 2'b10 || mem_addr !== 10'h020) begin
            fails++;
            $display("FAIL rr_tie1: gnt0=%b gnt1=%b addr=%h, required 1 0 020", p0_gnt, p1_gnt, mem_addr);
        end
        step();
        p0_req = 1'b0;
        #1;
        tests++;
        if ({p0_gnt, p1_gnt} !== 2'b01 || mem_addr !== 10'h021 || p0_rvalid !== 1'b1 || p0_rdata !== 32'hB0) begin
            fails++;
            $display("FAIL rr_tie1_second: gnt0=%b gnt1=%b addr=%h rv0=%b rd0=%h, required 0 1 021 1 000000b0",
                     p0_gnt, p1_gnt, mem_addr, p0_rvalid, p0_rdata);
        end
        step();
        p1_req = 1'b0;
        #1;
        tests++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hB1 || p0_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL rr_tie1_ret: rv1=%b rd1=%h rv0=%b, required 1 000000b1 0", p1_rvalid, p1_rdata, p0_rvalid);
        end
        $display("[TB] tie1 served p0 then p1");
        // Lone p0 single-beat write moves the pointer to p1.
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'h030; p0_wdata = 32'hC0; p0_last = 1'b1;
        step();
        #1;
        tests++;
        if ({p0_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 10'h030) begin
            fails++;
            $display("FAIL rr_single_wr: gnt0=%b en=%b we=%b addr=%h, required 1 1 1 030", p0_gnt, mem_en, mem_we, mem_addr);
        end
        step();
        p0_we = 1'b0; p0_addr = 10'h030; p0_last = 1'b1;
        p1_req = 1'b1; p1_addr = 10'h022;
        #1;
        tests++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin
            fails++;
            $display("FAIL rr_single_release: gnt0=%b gnt1=%b, required 0 0", p0_gnt, p1_gnt);
        end
        step();
        #1;
        tests++;
        if ({p0_gnt, p1_gnt} !== 2'b01 || mem_addr !== 10'h022) begin
            fails++;
            $display("FAIL rr_tie2: gnt0=%b gnt1=%b addr=%h, required 0 1 022", p0_gnt, p1_gnt, mem_addr);
        end
        step();
        p1_req = 1'b0;
        #1;
        tests++;
        if ({p0_gnt, p1_gnt} !== 2'b10 || mem_addr !== 10'h030 || p1_rvalid !== 1'b1 || p1_rdata !== 32'hB2) begin
            fails++;
            $display("FAIL rr_tie2_second: gnt0=%b gnt1=%b addr=%h rv1=%b rd1=%h, required 1 0 030 1 000000b2",
                     p0_gnt, p1_gnt, mem_addr, p1_rvalid, p1_rdata);
        end
        step();
        p0_req = 1'b0;
        #1;
        tests++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hC0 || p1_rvalid !== 1'b0 || p1_rdata !== 32'h0) begin
            fails++;
            $display("FAIL rr_tie2_ret: rv0=%b rd0=%h rv1=%b rd1=%h, required 1 000000c0 0 00000000",
                     p0_rvalid, p0_rdata, p1_rvalid, p1_rdata);
        end
        $display("[TB] tie2 served p1 then p0");
        step();
    endtask

    task automatic test_owner_drop();
        do_reset();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'h040; p0_wdata = 32'hD0; p0_last = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h030; p1_last = 1'b1;
        step();
        #1;
        tests++;
        if ({p0_gnt, p1_gnt, mem_en} !== 3'b101) begin
            fails++;
            $display("FAIL drop_first: gnt0=%b gnt1=%b en=%b, required 1 0 1", p0_gnt, p1_gnt, mem_en);
        end
        step();
        p0_req = 1'b0;
        #1;
        tests++;
        if ({p0_gnt, p1_gnt, mem_en, mem_addr} !== {3'b100, 10'h000}) begin
            fails++;
            $display("FAIL drop_idle_beat: gnt0=%b gnt1=%b en=%b addr=%h, required 1 0 0 000",
                     p0_gnt, p1_gnt, mem_en, mem_addr);
        end
        step();
        #1;
        tests++;
        if ({p0_gnt, p1_gnt, mem_en} !== 3'b011 || mem_addr !== 10'h030) begin
            fails++;
            $display("FAIL drop_handover: gnt0=%b gnt1=%b en=%b addr=%h, required 0 1 1 030",
                     p0_gnt, p1_gnt, mem_en, mem_addr);
        end
        step();
        p1_req = 1'b0;
        #1;
        tests++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hC0) begin
            fails++;
            $display("FAIL drop_read: rv1=%b rd1=%h, required 1 000000c0", p1_rvalid, p1_rdata);
        end
        $display("[TB] owner drop released lock to p1");
        step();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h010; p1_last = 1'b1;
        step();
        #1;
        tests++;
        if ({p1_gnt, mem_en, mem_we} !== 3'b110) begin
            fails++;
            $display("FAIL midrd_accept: gnt1=%b en=%b we=%b, required 1 1 0", p1_gnt, mem_en, mem_we);
        end
        ARESETn = 1'b0;
        p1_req = 1'b0;
        step();
        #1;
        tests++;
        if ({p0_rvalid, p1_rvalid, p0_gnt, p1_gnt, mem_en} !== 5'b0 || p1_rdata !== 32'h0) begin
            fails++;
            $display("FAIL midrd_abort: rv0=%b rv1=%b gnt0=%b gnt1=%b en=%b rd1=%h, required all 0",
                     p0_rvalid, p1_rvalid, p0_gnt, p1_gnt, mem_en, p1_rdata);
        end
        ARESETn = 1'b1;
        step();
        #1;
        tests++;
        if ({p1_rvalid, p0_gnt, p1_gnt} !== 3'b000) begin
            fails++;
            $display("FAIL midrd_idle: rv1=%b gnt0=%b gnt1=%b, required 0 0 0", p1_rvalid, p0_gnt, p1_gnt);
        end
        $display("[TB] reset mid-read suppressed rvalid");
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_latency();
        test_contention_lock();
        test_round_robin();
        test_owner_drop();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
